// File: rtl/conv_accum.sv
`default_nettype none
// ============================================================================
// Module   : conv_accum
// Purpose  : Convolution partial-sum accumulator. Each input beat carries
//            InputDim channel samples that a pipelined adder tree reduces to
//            one value. That value is accumulated per pixel across channel
//            groups through a partial-sum buffer. The final group adds the
//            result to the output register, with optional ReLU.
// Revision : 1.0 - initial release
// ============================================================================
module conv_accum #(
  parameter int DataWidth  = 16,
  parameter int InputDim   = 4,
  parameter int AccWidth   = 40,
  parameter int PixWidth   = 12,
  parameter int GroupWidth = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PixWidth:0]             cfg_pix_num,
  input  logic [GroupWidth-1:0]         cfg_groups,
  input  logic [AccWidth-1:0]           cfg_bias,
  input  logic                          cfg_relu,
  input  logic                          start,
  output logic                          busy,
  input  logic [InputDim*DataWidth-1:0] in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [AccWidth-1:0]           out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          done
);

  localparam int c_LEVELS = $clog2(InputDim);
  localparam int c_DEPTH  = 1 << PixWidth;
  localparam logic [PixWidth:0]     c_PIX_ONE = {{PixWidth{1'b0}}, 1'b1};
  localparam logic [PixWidth-1:0]   c_PIX_INC = {{(PixWidth-1){1'b0}}, 1'b1};
  localparam logic [GroupWidth-1:0] c_GRP_ONE = {{(GroupWidth-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [PixWidth:0]     r_cfg_pix_num;
  logic [GroupWidth-1:0] r_cfg_groups;
  logic [AccWidth-1:0]   r_cfg_bias;
  logic                  r_cfg_relu;
  logic [PixWidth-1:0]   r_pix_cnt;
  logic [PixWidth-1:0]   r_out_cnt;
  logic [GroupWidth-1:0] r_grp_cnt;
  logic                  r_busy;
  logic                  r_done;

  // Adder-tree levels: level 0 holds the sign-extended samples, level k holds
  // InputDim>>k partial sums. Tags travel alongside so the accumulate stage
  // knows which pixel/group the tree output belongs to.
  logic [AccWidth-1:0]   r_tree      [c_LEVELS+1][InputDim];
  logic                  r_vld       [c_LEVELS+1];
  logic [PixWidth-1:0]   r_tag_pix   [c_LEVELS+1];
  logic                  r_tag_first [c_LEVELS+1];
  logic                  r_tag_last  [c_LEVELS+1];

  logic [AccWidth-1:0]   r_buf [c_DEPTH];
  logic [AccWidth-1:0]   r_acc;
  logic                  r_acc_valid;
  logic [AccWidth-1:0]   r_out_data;
  logic                  r_out_valid;

  logic                  w_stall;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_pix_last;
  logic                  w_grp_last;
  logic                  w_out_last;
  logic                  w_cfg_ok;
  logic [AccWidth-1:0]   w_base;
  logic [AccWidth-1:0]   w_sum;
  logic [AccWidth-1:0]   w_sext [InputDim];

  // A held output freezes every pipeline stage, so nothing can overrun it.
  assign w_stall    = r_out_valid & ~out_ready;
  assign in_ready   = (r_state == ST_RUN) & ~w_stall;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_pix_last = ({1'b0, r_pix_cnt} == (r_cfg_pix_num - c_PIX_ONE));
  assign w_out_last = ({1'b0, r_out_cnt} == (r_cfg_pix_num - c_PIX_ONE));
  assign w_grp_last = (r_grp_cnt == (r_cfg_groups - c_GRP_ONE));
  assign w_cfg_ok   = (cfg_pix_num != '0) && (cfg_groups != '0);

  for (genvar gi = 0; gi < InputDim; gi++) begin : g_sext
    assign w_sext[gi] = {{(AccWidth-DataWidth){in_data[gi*DataWidth + DataWidth-1]}},
                         in_data[gi*DataWidth +: DataWidth]};
  end

  // Group 0 starts from the bias; later groups resume the buffered partial sum.
  // The buffer read is combinational, so a write on one edge is seen by the
  // very next beat (single-pixel planes stream without bubbles).
  assign w_base = r_tag_first[c_LEVELS] ? r_cfg_bias : r_buf[r_tag_pix[c_LEVELS]];
  assign w_sum  = w_base + r_tree[c_LEVELS][0];

  // Run control: config latch, pixel/group/output counters, busy and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cfg_pix_num <= '0;
      r_cfg_groups  <= '0;
      r_cfg_bias    <= '0;
      r_cfg_relu    <= 1'b0;
      r_pix_cnt     <= '0;
      r_out_cnt     <= '0;
      r_grp_cnt     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && w_cfg_ok) begin
            r_cfg_pix_num <= cfg_pix_num;
            r_cfg_groups  <= cfg_groups;
            r_cfg_bias    <= cfg_bias;
            r_cfg_relu    <= cfg_relu;
            r_pix_cnt     <= '0;
            r_out_cnt     <= '0;
            r_grp_cnt     <= '0;
            r_busy        <= 1'b1;
            r_state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_in_fire) begin
            if (w_pix_last) begin
              r_pix_cnt <= '0;
              if (w_grp_last) begin
                r_state <= ST_DRAIN;
              end else begin
                r_grp_cnt <= r_grp_cnt + c_GRP_ONE;
              end
            end else begin
              r_pix_cnt <= r_pix_cnt + c_PIX_INC;
            end
          end
          if (w_out_fire) begin
            r_out_cnt <= r_out_cnt + c_PIX_INC;
          end
        end
        ST_DRAIN: begin
          if (w_out_fire) begin
            if (w_out_last) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_out_cnt <= r_out_cnt + c_PIX_INC;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pipeline valids and the output register advance together when not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= c_LEVELS; k++) begin
        r_vld[k] <= 1'b0;
      end
      r_acc_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (!w_stall) begin
      r_vld[0] <= w_in_fire;
      for (int k = 1; k <= c_LEVELS; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
      r_acc_valid <= r_vld[c_LEVELS] & r_tag_last[c_LEVELS];
      r_out_valid <= r_acc_valid;
      r_out_data  <= (r_cfg_relu && r_acc[AccWidth-1]) ? '0 : r_acc;
    end
  end

  // Datapath: adder tree levels, their tags, and the accumulated sum.
  always_ff @(posedge clk) begin
    if (!w_stall) begin
      for (int i = 0; i < InputDim; i++) begin
        r_tree[0][i] <= w_sext[i];
      end
      r_tag_pix[0]   <= r_pix_cnt;
      r_tag_first[0] <= (r_grp_cnt == '0);
      r_tag_last[0]  <= w_grp_last;
      for (int k = 1; k <= c_LEVELS; k++) begin
        r_tag_pix[k]   <= r_tag_pix[k-1];
        r_tag_first[k] <= r_tag_first[k-1];
        r_tag_last[k]  <= r_tag_last[k-1];
        for (int i = 0; i < (InputDim >> k); i++) begin
          r_tree[k][i] <= r_tree[k-1][2*i] + r_tree[k-1][2*i+1];
        end
      end
      r_acc <= w_sum;
    end
  end

  // Partial sums of non-final groups are parked per pixel for the next group.
  always_ff @(posedge clk) begin
    if (!w_stall && r_vld[c_LEVELS] && !r_tag_last[c_LEVELS]) begin
      r_buf[r_tag_pix[c_LEVELS]] <= w_sum;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_accum
// Purpose  : Self-checking bench for conv_accum. Directed scenarios use the
//            known pixel results; random runs compare against a per-pixel
//            model: bias + sum of every sample of every group, modulo 2^40,
//            with optional ReLU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_accum;

  localparam int DW = 16;
  localparam int ID = 4;
  localparam int AW = 40;
  localparam int PW = 12;
  localparam int GW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PW:0]       cfg_pix_num;
  logic [GW-1:0]     cfg_groups;
  logic [AW-1:0]     cfg_bias;
  logic              cfg_relu;
  logic              start;
  logic              busy;
  logic [ID*DW-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              done;

  conv_accum #(
    .DataWidth(DW), .InputDim(ID), .AccWidth(AW), .PixWidth(PW), .GroupWidth(GW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_pix_num(cfg_pix_num), .cfg_groups(cfg_groups), .cfg_bias(cfg_bias),
    .cfg_relu(cfg_relu), .start(start), .busy(busy),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] stim [0:511][0:ID-1];
  logic [AW-1:0] out_q [$];
  logic [AW-1:0] exp_q [$];

  int done_cnt, first_beat_cyc, last_beat_cyc, first_out_cyc;
  int early_valid, stall_cycles, stall_viol, drain_ready_viol;
  bit busy_at_first;

  function automatic logic [ID*DW-1:0] pack(input int b);
    logic [ID*DW-1:0] p;
    for (int c = 0; c < ID; c++) p[c*DW +: DW] = stim[b][c];
    return p;
  endfunction

  // Reference: each pixel is bias plus every sample of every group.
  task automatic model(input int npix, input int ngrp, input logic [AW-1:0] bias, input bit relu);
    exp_q.delete();
    for (int p = 0; p < npix; p++) begin
      logic [AW-1:0] acc;
      acc = bias;
      for (int g = 0; g < ngrp; g++) begin
        for (int c = 0; c < ID; c++) begin
          logic [DW-1:0] s;
          s = stim[g*npix + p][c];
          acc = acc + {{(AW-DW){s[DW-1]}}, s};
        end
      end
      if (relu && acc[AW-1]) acc = '0;
      exp_q.push_back(acc);
    end
  endtask

  // Runs one job; ready_mode 0=always ready, 1=5-cycle stall window, 2=random.
  task automatic run_job(input int npix, input int ngrp, input logic [AW-1:0] bias,
                         input bit relu, input int ready_mode, input bit gaps,
                         input int abort_beat);
    int total = npix * ngrp;
    int beat = 0;
    int cyc = 0;
    bit fin = 0;
    bit aborted = 0;
    bit prev_stall = 0;
    logic [AW-1:0] prev_data = '0;
    out_q.delete();
    done_cnt = 0; first_beat_cyc = -1; last_beat_cyc = -1; first_out_cyc = -1;
    early_valid = 0; stall_cycles = 0; stall_viol = 0; drain_ready_viol = 0;
    @(negedge clk);
    cfg_pix_num = (PW+1)'(npix);
    cfg_groups  = GW'(ngrp);
    cfg_bias    = bias;
    cfg_relu    = relu;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Configuration inputs wander after the start edge; the run must ignore them.
    cfg_pix_num = (PW+1)'($urandom_range(1, 4096));
    cfg_groups  = GW'($urandom_range(1, 255));
    cfg_bias    = AW'({$urandom(), $urandom()});
    cfg_relu    = ~relu;
    busy_at_first = busy;
    while (!fin && !aborted && cyc < 3000) begin
      if (done) begin
        done_cnt++;
        fin = 1;
      end else if (abort_beat >= 0 && beat == abort_beat) begin
        aborted = 1;
      end else begin
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = !(cyc >= 6 && cyc < 11);
          default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (beat < total && (!gaps || $urandom_range(0, 3) != 0)) begin
          in_valid = 1'b1;
          in_data  = pack(beat);
        end else begin
          in_valid = 1'b0;
          in_data  = {$urandom(), $urandom()};
        end
        start = (beat > 0 && beat < total) ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        if (prev_stall && (out_data !== prev_data || !out_valid)) stall_viol++;
        if (out_valid && !out_ready) begin
          stall_cycles++;
          if (in_ready) stall_viol++;
        end
        if (in_ready && beat >= total) drain_ready_viol++;
        if (out_valid) begin
          if (first_out_cyc < 0) first_out_cyc = cyc;
          if (beat <= (ngrp - 1) * npix) early_valid++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && out_ready) out_q.push_back(out_data);
        if (in_valid && in_ready) begin
          if (beat == 0) first_beat_cyc = cyc;
          last_beat_cyc = cyc;
          beat++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    if (!fin && !aborted) begin
      n_checks++; n_fail++;
      $display("FAIL run_timeout: no done within %0d cycles, beats=%0d outputs=%0d", cyc, beat, out_q.size());
    end
    if (fin) repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
    cfg_pix_num = 13'd4; cfg_groups = 8'd1; cfg_bias = '0; cfg_relu = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_illegal_start();
    in_valid = 1'b1;
    cfg_pix_num = '0; cfg_groups = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_pix_start: busy=%b in_ready=%b want 0/0", busy, in_ready); end
    @(negedge clk);
    cfg_pix_num = 13'd3; cfg_groups = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_grp_start: busy=%b in_ready=%b want 0/0", busy, in_ready); end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [AW-1:0] want [4];
    want = '{40'd14, 40'd18, 40'd22, 40'd26};
    for (int p = 0; p < 4; p++) for (int c = 0; c < ID; c++) stim[p][c] = DW'(p + 1);
    run_job(4, 1, 40'd10, 1'b0, 0, 1'b0, -1);
    n_checks++; if (out_q.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      n_checks++; if (out_q[i] !== want[i]) begin n_fail++; $display("FAIL basic_pix%0d: got %0d want %0d", i, out_q[i], want[i]); end
    end
    n_checks++; if ((first_out_cyc - 1) - first_beat_cyc != 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", (first_out_cyc - 1) - first_beat_cyc); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
    n_checks++; if (busy_at_first !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: during=%b after=%b want 1/0", busy_at_first, busy); end
    in_valid = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_groups();
    for (int b = 0; b < 6; b++) for (int c = 0; c < ID; c++) stim[b][c] = 16'd1;
    run_job(2, 3, 40'd0, 1'b0, 0, 1'b0, -1);
    n_checks++; if (out_q.size() != 2) begin n_fail++; $display("FAIL groups_count: got %0d want 2", out_q.size()); end
    for (int i = 0; i < 2 && i < out_q.size(); i++) begin
      n_checks++; if (out_q[i] !== 40'd12) begin n_fail++; $display("FAIL groups_pix%0d: got %0d want 12", i, out_q[i]); end
    end
    n_checks++; if (early_valid != 0) begin n_fail++; $display("FAIL groups_early_valid: got %0d want 0", early_valid); end
  endtask

  task automatic test_back_to_back();
    for (int g = 0; g < 4; g++) for (int c = 0; c < ID; c++) stim[g][c] = DW'(g + 1);
    run_job(1, 4, 40'd0, 1'b0, 0, 1'b0, -1);
    n_checks++; if (out_q.size() != 1 || out_q[0] !== 40'd40) begin n_fail++; $display("FAIL b2b_result: count=%0d got %0d want 1 x 40", out_q.size(), (out_q.size() > 0) ? out_q[0] : '0); end
    n_checks++; if (last_beat_cyc - first_beat_cyc != 3) begin n_fail++; $display("FAIL b2b_no_stall: beat span %0d want 3", last_beat_cyc - first_beat_cyc); end
  endtask

  task automatic test_bias_relu();
    for (int c = 0; c < ID; c++) stim[0][c] = 16'd5;
    run_job(1, 1, -40'sd100, 1'b0, 0, 1'b0, -1);
    n_checks++; if (out_q.size() != 1 || out_q[0] !== 40'hFF_FFFF_FFB0) begin n_fail++; $display("FAIL bias_neg80: got %h want ffffffffb0", (out_q.size() > 0) ? out_q[0] : '0); end
    run_job(1, 1, -40'sd100, 1'b1, 0, 1'b0, -1);
    n_checks++; if (out_q.size() != 1 || out_q[0] !== 40'd0) begin n_fail++; $display("FAIL relu_clamp: got %h want 0", (out_q.size() > 0) ? out_q[0] : '0); end
  endtask

  task automatic test_stall();
    for (int b = 0; b < 8; b++) for (int c = 0; c < ID; c++) stim[b][c] = DW'($urandom());
    model(8, 1, 40'd3, 1'b0);
    run_job(8, 1, 40'd3, 1'b0, 1, 1'b0, -1);
    n_checks++; if (out_q.size() != 8) begin n_fail++; $display("FAIL stall_count: got %0d want 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      n_checks++; if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_pix%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    n_checks++; if (stall_cycles != 5) begin n_fail++; $display("FAIL stall_cycles: got %0d want 5", stall_cycles); end
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL stall_hold: got %0d violations want 0", stall_viol); end
  endtask

  task automatic test_reset_midrun();
    for (int b = 0; b < 12; b++) for (int c = 0; c < ID; c++) stim[b][c] = DW'($urandom());
    run_job(4, 3, 40'd1234, 1'b0, 0, 1'b0, 6);
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL midrst_out: valid=%b data=%h want 0/0", out_valid, out_data); end
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctl: in_ready=%b busy=%b done=%b want 0/0/0", in_ready, busy, done); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 4; b++) for (int c = 0; c < ID; c++) stim[b][c] = 16'd1;
    run_job(4, 1, 40'd7, 1'b0, 0, 1'b0, -1);
    n_checks++; if (out_q.size() != 4) begin n_fail++; $display("FAIL midrst_rerun_count: got %0d want 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      n_checks++; if (out_q[i] !== 40'd11) begin n_fail++; $display("FAIL midrst_rerun_pix%0d: got %0d want 11", i, out_q[i]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int np = $urandom_range(1, 6);
      int ng = $urandom_range(1, 4);
      logic [AW-1:0] bias = AW'({$urandom(), $urandom()});
      bit relu = 1'($urandom_range(0, 1));
      for (int b = 0; b < np * ng; b++) for (int c = 0; c < ID; c++) stim[b][c] = DW'($urandom());
      model(np, ng, bias, relu);
      run_job(np, ng, bias, relu, 2, 1'b1, -1);
      n_checks++; if (out_q.size() != np) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", it, out_q.size(), np); end
      for (int i = 0; i < np && i < out_q.size(); i++) begin
        n_checks++; if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_pix%0d: got %h want %h", it, i, out_q[i], exp_q[i]); end
      end
      n_checks++; if (stall_viol != 0 || drain_ready_viol != 0 || early_valid != 0) begin n_fail++; $display("FAIL rand%0d_protocol: stall=%0d drain_ready=%0d early=%0d want 0", it, stall_viol, drain_ready_viol, early_valid); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d want 1", it, done_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_illegal_start();
    test_basic();
    test_groups();
    test_back_to_back();
    test_bias_relu();
    test_stall();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_accum.md
CONV_ACCUM -- requirements
Module: conv_accum

Interface
REQ-001 Parameter DataWidth, 16, signed width of each per-channel input sample.
REQ-002 Parameter InputDim, 4, channels summed per beat; power of two, >=2.
REQ-003 Parameter AccWidth, 40, signed width of accumulator and result; >= DataWidth+log2(InputDim)+8.
REQ-004 Parameter PixWidth, 12, partial-sum buffer address width; buffer depth 2^PixWidth.
REQ-005 Parameter GroupWidth, 8, width of the group-count config.
REQ-006 Clk  in  1  sole clock; all state changes on rising edge.
REQ-007 Rst_n  in  1  asynchronous active-low reset.
REQ-008 cfg_pix_num  in  PixWidth+1  pixels per plane, legal 1..2^PixWidth.
REQ-009 cfg_groups  in  GroupWidth  input-channel groups to accumulate, legal 1..2^GroupWidth-1.
REQ-010 cfg_bias  in  AccWidth  signed bias added once per output pixel.
REQ-011 cfg_relu  in  1  1 = clamp negative results to 0.
REQ-012 start  in  1  run request; sampled only in IDLE.
REQ-013 busy  out  1  high from accepted start until done.
REQ-014 in_data  in  InputDim*DataWidth  channel samples; channel i at [i*DataWidth +: DataWidth].
REQ-015 in_valid / in_ready  in / out  1 each  input handshake; transfer when both high.
REQ-016 out_data  out  AccWidth  final accumulated pixel result.
REQ-017 out_valid / out_ready  out / in  1 each  output handshake.
REQ-018 done  out  1  one-cycle pulse at run completion.

Function
REQ-019 FSM: IDLE -> RUN on start=1 with legal cfg; RUN -> DRAIN when the last of cfg_pix_num*cfg_groups beats is accepted; DRAIN -> IDLE when the last output is accepted.
REQ-020 cfg_* latched on the start edge; changes during RUN/DRAIN have no effect.
REQ-021 start with cfg_pix_num=0 or cfg_groups=0 is ignored; FSM stays IDLE.
REQ-022 Input order: group 0 pixels 0..N-1, then group 1 pixels 0..N-1, and so on; pixel and group counters advance per accepted beat.
REQ-023 Per beat, the InputDim samples are sign-extended to AccWidth and summed by a registered adder tree with log2(InputDim) stages.
REQ-024 Accumulate stage: base = cfg_bias for group 0, otherwise buffer[pixel]; sum = base + tree output.
REQ-025 For every group except the last, sum is written to buffer[pixel]. The write is visible to a read on the next cycle, so cfg_pix_num=1 back-to-back needs no stall.
REQ-026 Last group: sum (ReLU applied if cfg_relu) goes to the output register; no buffer write.
REQ-027 All arithmetic is two's complement modulo 2^AccWidth, with no saturation.
REQ-028 Unstalled latency: a handshake at edge t gives out_valid at edge t+log2(InputDim)+2.
REQ-029 Stall: while out_valid=1 and out_ready=0, the whole pipeline holds, out_data stays stable, and in_ready=0.
REQ-030 in_ready = 1 only in RUN, when not stalled, and while beats remain; it is 0 in IDLE and DRAIN.
REQ-031 Exactly cfg_pix_num outputs per run, in pixel order 0..N-1; no output for non-final groups.
REQ-032 done pulses high for one cycle on the edge after the final output handshake; busy falls on that same edge.
REQ-033 start while busy is ignored.

Reset
REQ-034 Rst_n low asynchronously forces IDLE and clears counters, pipeline valids, out_data, out_valid, in_ready, busy and done to 0.
REQ-035 Buffer contents are not reset and are never read before being written within a run.
REQ-036 Reset mid-run aborts the run; the next run is unaffected by stale state.

Verification (InputDim=4, DataWidth=16, AccWidth=40)
REQ-037 pix=4, groups=1, bias=10, relu=0; all channels of pixel p = p+1 -> outputs 14, 18, 22, 26; first out_valid 4 cycles after the first beat; done once.
REQ-038 pix=2, groups=3, bias=0; every sample = 1 -> outputs 12, 12; no out_valid during groups 0-1.
REQ-039 pix=1, groups=4, back-to-back; group g samples = g+1, bias=0 -> single output 40.
REQ-040 bias=-100, samples=5: with relu=0 -> out_data = -80 in two's complement; with relu=1 -> 0.
REQ-041 pix=8, groups=1; out_ready low for 5 cycles mid-stream -> out_data held stable, in_ready=0, all 8 outputs correct and in order.
REQ-042 Rst_n low during group 1 of pix=4, groups=3 -> all outputs 0 and IDLE; the next run (bias=7, samples=1, groups=1) -> 11, 11, 11, 11.
